// File: rtl/instr_fetch.sv
// Instruction fetch stage of the RV32I core.
// Holds the PC and issues in-order word reads to instruction memory. Returned
// words go into a small PC-tagged queue and are handed to decode through a
// valid/ready handshake. Redirects flush the queue and drop in-flight replies.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_ready    request channel to instruction memory
//   imem_rvalid/imem_rdata           in-order response channel
//   redirect_valid/redirect_pc       branch/jump redirect, flushes the stage
//   if_valid/if_instr/if_pc/if_ready instruction handshake to decode
//   err_spurious                     sticky flag: response with nothing outstanding
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        err_spurious
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

    // Queue storage; pointers carry one extra wrap bit so full and empty differ.
    logic [31:0]      q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;

    logic [31:0] pc;
    logic [PW:0] head;      // oldest entry, presented to decode
    logic [PW:0] fptr;      // oldest entry still waiting for its response
    logic [PW:0] tail;      // next entry to allocate
    logic [PW:0] drop_cnt;  // responses still owed to a flushed stream
    logic        err_q;

    logic [PW-1:0] head_idx;
    logic [PW-1:0] fptr_idx;
    logic [PW-1:0] tail_idx;
    logic [PW:0]   count;
    logic [PW:0]   unfilled;
    logic [PW:0]   credit_used;
    logic [PW:0]   rsp_taken;
    logic          accept;
    logic          consume;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          rsp_spur;

    assign head_idx    = head[PW-1:0];
    assign fptr_idx    = fptr[PW-1:0];
    assign tail_idx    = tail[PW-1:0];
    assign count       = tail - head;
    assign unfilled    = tail - fptr;
    assign credit_used = count + drop_cnt;

    // Request stays up while credit remains; a redirect cycle never issues.
    assign imem_req  = ~rst & (credit_used < DEPTH_W) & ~redirect_valid;
    assign imem_addr = pc;

    // Decode side is driven straight from queue registers.
    assign if_valid     = q_filled[head_idx];
    assign if_instr     = q_instr[head_idx];
    assign if_pc        = q_pc[head_idx];
    assign err_spurious = err_q;

    assign accept   = imem_req & imem_ready;
    assign consume  = if_valid & if_ready;
    assign rsp_drop = imem_rvalid & (drop_cnt != '0);
    assign rsp_fill = imem_rvalid & (drop_cnt == '0) & (unfilled != '0);
    assign rsp_spur = imem_rvalid & (drop_cnt == '0) & (unfilled == '0);
    assign rsp_taken = (PW + 1)'(rsp_drop | rsp_fill);

    // Queue, PC and drop bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC & ~32'h3;
            head     <= '0;
            fptr     <= '0;
            tail     <= '0;
            drop_cnt <= '0;
            err_q    <= 1'b0;
            q_filled <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            if (rsp_spur) begin
                err_q <= 1'b1;
            end

            if (redirect_valid) begin
                // Every unfilled slot still has a reply on the way; a reply
                // arriving this cycle belongs to the old stream and is already
                // accounted for by rsp_taken.
                pc       <= redirect_pc & ~32'h3;
                head     <= '0;
                fptr     <= '0;
                tail     <= '0;
                q_filled <= '0;
                drop_cnt <= drop_cnt + unfilled - rsp_taken;
            end else begin
                if (accept) begin
                    q_pc[tail_idx] <= pc;
                    tail           <= tail + 1'b1;
                    pc             <= pc + 32'd4;
                end

                if (rsp_fill) begin
                    q_instr[fptr_idx]  <= imem_rdata;
                    q_filled[fptr_idx] <= 1'b1;
                    fptr               <= fptr + 1'b1;
                end else if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end

                // Head is filled when consumed, so it never aliases fptr or tail.
                if (consume) begin
                    q_filled[head_idx] <= 1'b0;
                    head               <= head + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the RV32I core, directly upstream of opcode decode. It holds the PC and issues in-order word reads to instruction memory over a req/ready and rvalid interface. Returned words are buffered in a small PC-tagged queue and presented to decode with a valid/ready handshake. Branch and jump redirects flush the queue and discard responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 4, queue entries; also the maximum number of outstanding requests plus buffered words (power of 2, at least 2).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  read request valid
imem_addr  out  32  word address (bits [1:0] always 00)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  32  response instruction word
redirect_valid  in  1  branch/jump taken, flush
redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 00
if_valid  out  1  instruction available to decode
if_instr  out  32  instruction word (decode takes opcode from if_instr[6:0])
if_pc  out  32  PC of if_instr
if_ready  in  1  decode consumes this cycle
err_spurious  out  1  sticky; set on rvalid with nothing outstanding

Behaviour:
- Reset (async): pc=RESET_PC; queue empty; drop_cnt=0; imem_req=0, if_valid=0, if_instr=0, if_pc=0, err_spurious=0. The first request is issued in the first cycle after rst deasserts.
- Queue entry = {pc, instr, filled}. A slot is allocated when a request is accepted and filled when its response arrives. count = allocated entries.
- Issue: imem_req=1 when (count + drop_cnt) < DEPTH and redirect_valid=0. imem_addr=pc.
- Request accept (imem_req && imem_ready): allocate tail with pc; pc <= pc+4, wrapping mod 2^32.
- While imem_req=1 and imem_ready=0, imem_addr stays stable and imem_req stays high, unless a redirect arrives.
- Response: if drop_cnt>0, discard the word and decrement drop_cnt. Otherwise write imem_rdata into the oldest unfilled entry and set filled.
- Spurious response (rvalid with drop_cnt=0 and no unfilled entry): ignore the word and set err_spurious, which is cleared only by rst.
- Output: if_valid = head.filled; if_instr/if_pc = head fields. All outputs are registered from the queue state; there is no combinational path from imem_rdata to if_instr.
- Latency: a response in cycle N gives if_valid in cycle N+1 at the earliest.
- Consume (if_valid && if_ready): pop head.
- if_instr and if_pc stay stable while if_valid=1 and if_ready=0.
- Redirect (registered, highest priority):
  - pc <= {redirect_pc[31:2],2'b00}.
  - All entries are cleared, and if_valid=0 next cycle.
  - Any consume in the same cycle is ignored.
  - drop_cnt <= drop_cnt + (unfilled entries) - (rvalid this cycle ? 1 : 0). A same-cycle response always belongs to the old stream.
  - imem_req=0 in the redirect cycle, so no request from the old stream is accepted. Requests resume next cycle from the new pc when credit allows.
- Simultaneous same-cycle events without redirect: accept, fill and consume all apply. Counters update as one net change.
- Full: count + drop_cnt = DEPTH → imem_req=0 until a consume or a drop frees credit. Credit freed in cycle N allows a request in cycle N+1.
- Throughput: with memory latency 1, imem_ready=1 and if_ready=1, one instruction per cycle is sustained after the initial fill.
- Reset mid-operation: all state returns to reset values immediately. Responses still outstanding from before reset are the memory's responsibility; the memory must also be reset.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, imem_ready=1, if_ready=1 → addresses 0x0,0x4,0x8,… on consecutive cycles. if_pc/if_instr pairs match, in order, and one per cycle after the first if_valid.
- if_ready=0 held → exactly 4 requests accepted (0x0..0xC), then imem_req=0. if_pc holds 0x0. Raising if_ready gives 0x0,0x4,0x8,0xC, then requests resume at 0x10.
- imem_ready=0 for 3 cycles with a request pending → imem_addr constant at 0x8 and imem_req high. The request is accepted when ready rises, with no duplicate or skipped address.
- Latency 3, two requests in flight, redirect_pc=0x0000_0103 → next imem_addr=0x100. The two old responses are discarded, and the first if_pc after the redirect is 0x100.
- Redirect in the same cycle as an rvalid and an if_ready consume → drop_cnt reflects the same-cycle drop. No old instruction reaches decode; the first output is from redirect_pc.
- rvalid pulse with nothing outstanding → err_spurious=1 and stays set, with no effect on if_valid. rst clears it and reloads RESET_PC.
